// File: rtl/seq_pattern_serial_tx.sv
// seq_pattern_serial_tx: bit-serial repeating pattern transmitter with idle gaps, valid/ready output and abort
module seq_pattern_serial_tx #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b11011,
  parameter int               GAP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] repeat_cnt,
  input  logic       abort,
  input  logic       out_ready,
  output logic       out,
  output logic       out_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       all_done,
  output logic [7:0] frames_sent
);
  localparam int IW = $clog2(PAT_W);
  localparam logic [IW-1:0] TOP = IW'(PAT_W - 1);
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n, idx_dec;
  logic [3:0] gcnt, gcnt_n;
  logic [7:0] reps, reps_n, fs_n, fs_inc;
  logic out_n, ov_n, fd_n, ad_n;
  assign idx_dec = idx - IW'(1);
  assign fs_inc = frames_sent + 8'd1;
  // state and all outputs are registered; rst clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      gcnt        <= '0;
      reps        <= '0;
      frames_sent <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      all_done    <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      gcnt        <= gcnt_n;
      reps        <= reps_n;
      frames_sent <= fs_n;
      out         <= out_n;
      out_valid   <= ov_n;
      busy        <= state_n != ST_IDLE;
      frame_done  <= fd_n;
      all_done    <= ad_n;
    end
  end
  // next-state and next-output decode; abort takes priority over start and over an LSB transfer
  always_comb begin
    state_n = state;
    idx_n   = idx;
    gcnt_n  = gcnt;
    reps_n  = reps;
    fs_n    = frames_sent;
    out_n   = out;
    ov_n    = out_valid;
    fd_n    = 1'b0;
    ad_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        out_n = 1'b0;
        ov_n  = 1'b0;
        if (start && !abort && repeat_cnt != 8'd0) begin
          state_n = ST_SEND;
          reps_n  = repeat_cnt;
          fs_n    = 8'd0;
          idx_n   = TOP;
          out_n   = PATTERN[PAT_W-1];
          ov_n    = 1'b1;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_n = ST_IDLE;
          out_n   = 1'b0;
          ov_n    = 1'b0;
        end else if (out_ready) begin
          if (idx != '0) begin
            idx_n = idx_dec;
            out_n = PATTERN[idx_dec];
          end else begin
            fs_n = fs_inc;
            fd_n = 1'b1;
            if (fs_inc == reps) begin
              ad_n    = 1'b1;
              state_n = ST_IDLE;
              out_n   = 1'b0;
              ov_n    = 1'b0;
            end else if (GAP > 0) begin
              state_n = ST_GAP;
              gcnt_n  = 4'(GAP - 1);
              out_n   = 1'b0;
              ov_n    = 1'b0;
            end else begin
              idx_n = TOP;
              out_n = PATTERN[PAT_W-1];
            end
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_n = ST_IDLE;
          out_n   = 1'b0;
          ov_n    = 1'b0;
        end else if (gcnt == 4'd0) begin
          state_n = ST_SEND;
          idx_n   = TOP;
          out_n   = PATTERN[PAT_W-1];
          ov_n    = 1'b1;
        end else begin
          gcnt_n = gcnt - 4'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        out_n   = 1'b0;
        ov_n    = 1'b0;
      end
    endcase
  end
endmodule
